// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - CPU, DMA and memory port bundle for mem_arbiter
// master is the arbiter side, slave is the CPU/DMA/memory environment.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ready;

  logic          dma_req;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_rdata;
  logic          dma_ready;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [1:0]    gnt;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, dma_req, dma_addr, mem_rdata,
    output cpu_rdata, cpu_ready, dma_rdata, dma_ready,
    output mem_en, mem_we, mem_addr, mem_wdata, gnt
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, dma_req, dma_addr, mem_rdata,
    input  cpu_rdata, cpu_ready, dma_rdata, dma_ready,
    input  mem_en, mem_we, mem_addr, mem_wdata, gnt
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin CPU/DMA arbiter for one fixed-latency memory port
// Ownership is decided in IDLE; request fields are latched so the owner may change them mid-access.
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic       OWN_CPU = 1'b0;
  localparam logic       OWN_DMA = 1'b1;
  localparam logic [3:0] LAT     = 4'(MEM_LAT);

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          owner_q, owner_d;
  logic          last_owner_q, last_owner_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] dma_rdata_q, dma_rdata_d;
  logic          pick_dma;

  // DMA wins a tie only when the CPU was the most recent owner.
  assign pick_dma = bus.dma_req & (~bus.cpu_req | (last_owner_q == OWN_CPU));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.cpu_req || bus.dma_req) begin
          owner_d = pick_dma ? OWN_DMA : OWN_CPU;
          addr_d  = pick_dma ? bus.dma_addr : bus.cpu_addr;
          we_d    = ~pick_dma & bus.cpu_we;
          wdata_d = pick_dma ? '0 : bus.cpu_wdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = LAT;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          if (!we_q && owner_q == OWN_DMA) dma_rdata_d = bus.mem_rdata;
          if (!we_q && owner_q == OWN_CPU) cpu_rdata_d = bus.mem_rdata;
          state_d = DONE;
        end
      end
      DONE: begin
        last_owner_d = owner_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      owner_q      <= OWN_CPU;
      last_owner_q <= OWN_DMA;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

  // Outputs decode from state so an asynchronous reset clears them at once.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.gnt       = 2'b00;
    if (state_q == ISSUE) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = we_q;
      bus.mem_addr  = addr_q;
      bus.mem_wdata = wdata_q;
    end
    if (state_q != IDLE) bus.gnt = (owner_q == OWN_DMA) ? 2'b10 : 2'b01;
    bus.cpu_ready = (state_q == DONE) && (owner_q == OWN_CPU);
    bus.dma_ready = (state_q == DONE) && (owner_q == OWN_DMA);
  end

  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dma_rdata = dma_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter at MEM_LAT 1 and 3
// dut1 memory answers per address one cycle after mem_en; dut3 memory returns a per-cycle stamp.
module tb_mem_arbiter;
  typedef struct {
    logic        port;
    logic [31:0] rdata;
    logic [31:0] cyc;
  } rexp_t;

  typedef struct {
    logic        own;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] cyc;
  } mexp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] cyc = 32'd0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] cpu_rd1;
  logic [31:0] t;

  rexp_t rq1[$];
  rexp_t rq3[$];
  mexp_t mq1[$];
  mexp_t mq3[$];

  mem_arbiter_if #(.AW(32), .DW(32)) bus1 ();
  mem_arbiter_if #(.AW(32), .DW(32)) bus3 ();

  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  function automatic logic [31:0] mrd1(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  always @(posedge clk) begin
    if (bus1.mem_en) bus1.mem_rdata <= mrd1(bus1.mem_addr);
    else             bus1.mem_rdata <= 32'hBAD0BAD0;
  end
  assign bus3.mem_rdata = {16'hC0DE, cyc[15:0]};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    rexp_t r;
    mexp_t m;
    check("ready_excl1", 64'(bus1.cpu_ready & bus1.dma_ready), 64'(0));
    if (bus1.cpu_ready || bus1.dma_ready) begin
      if (rq1.size() == 0) check("spurious_ready1", 64'(1), 64'(0));
      else begin
        r = rq1.pop_front();
        check("ready_port1", 64'(bus1.dma_ready), 64'(r.port));
        check("ready_cyc1", 64'(cyc), 64'(r.cyc));
        check("rdata1", 64'(r.port ? bus1.dma_rdata : bus1.cpu_rdata), 64'(r.rdata));
        check("gnt_done1", 64'(bus1.gnt), 64'(r.port ? 2'b10 : 2'b01));
      end
    end
    if (bus1.mem_en) begin
      if (mq1.size() == 0) check("spurious_mem_en1", 64'(1), 64'(0));
      else begin
        m = mq1.pop_front();
        check("mem_cyc1", 64'(cyc), 64'(m.cyc));
        check("mem_we1", 64'(bus1.mem_we), 64'(m.we));
        check("mem_addr1", 64'(bus1.mem_addr), 64'(m.addr));
        check("mem_wdata1", 64'(bus1.mem_wdata), 64'(m.wdata));
        check("gnt_issue1", 64'(bus1.gnt), 64'(m.own ? 2'b10 : 2'b01));
      end
    end else begin
      check("mem_idle1", 64'(bus1.mem_we | (|bus1.mem_addr) | (|bus1.mem_wdata)), 64'(0));
    end
  end

  always @(negedge clk) begin
    rexp_t r;
    mexp_t m;
    check("ready_excl3", 64'(bus3.cpu_ready & bus3.dma_ready), 64'(0));
    if (bus3.cpu_ready || bus3.dma_ready) begin
      if (rq3.size() == 0) check("spurious_ready3", 64'(1), 64'(0));
      else begin
        r = rq3.pop_front();
        check("ready_port3", 64'(bus3.dma_ready), 64'(r.port));
        check("ready_cyc3", 64'(cyc), 64'(r.cyc));
        check("rdata3", 64'(r.port ? bus3.dma_rdata : bus3.cpu_rdata), 64'(r.rdata));
        check("gnt_done3", 64'(bus3.gnt), 64'(r.port ? 2'b10 : 2'b01));
      end
    end
    if (bus3.mem_en) begin
      if (mq3.size() == 0) check("spurious_mem_en3", 64'(1), 64'(0));
      else begin
        m = mq3.pop_front();
        check("mem_cyc3", 64'(cyc), 64'(m.cyc));
        check("mem_we3", 64'(bus3.mem_we), 64'(m.we));
        check("mem_addr3", 64'(bus3.mem_addr), 64'(m.addr));
        check("gnt_issue3", 64'(bus3.gnt), 64'(m.own ? 2'b10 : 2'b01));
      end
    end else begin
      check("mem_idle3", 64'(bus3.mem_we | (|bus3.mem_addr) | (|bus3.mem_wdata)), 64'(0));
    end
  end

  initial begin
    bus1.cpu_req = 1'b0; bus1.cpu_we = 1'b0; bus1.cpu_addr = '0; bus1.cpu_wdata = '0;
    bus1.dma_req = 1'b0; bus1.dma_addr = '0;
    bus3.cpu_req = 1'b0; bus3.cpu_we = 1'b0; bus3.cpu_addr = '0; bus3.cpu_wdata = '0;
    bus3.dma_req = 1'b0; bus3.dma_addr = '0;
    step(2);
    check("rst_gnt1", 64'(bus1.gnt), 64'(0));
    check("rst_mem_en1", 64'(bus1.mem_en), 64'(0));
    check("rst_cpu_rdata1", 64'(bus1.cpu_rdata), 64'(0));
    check("rst_dma_rdata1", 64'(bus1.dma_rdata), 64'(0));
    check("rst_ready3", 64'({bus3.cpu_ready, bus3.dma_ready}), 64'(0));
    reset = 1'b1;
    step(2);

    // CPU read of 0x10
    t = cyc;
    bus1.cpu_req = 1'b1; bus1.cpu_we = 1'b0; bus1.cpu_addr = 32'h10;
    mq1.push_back('{own: 1'b0, we: 1'b0, addr: 32'h10, wdata: 32'h0, cyc: t + 1});
    rq1.push_back('{port: 1'b0, rdata: 32'hDEADBEEF, cyc: t + 3});
    cpu_rd1 = 32'hDEADBEEF;
    step(3); bus1.cpu_req = 1'b0; step(1);

    // CPU write leaves cpu_rdata untouched
    t = cyc;
    bus1.cpu_req = 1'b1; bus1.cpu_we = 1'b1; bus1.cpu_addr = 32'h20; bus1.cpu_wdata = 32'h12345678;
    mq1.push_back('{own: 1'b0, we: 1'b1, addr: 32'h20, wdata: 32'h12345678, cyc: t + 1});
    rq1.push_back('{port: 1'b0, rdata: cpu_rd1, cyc: t + 3});
    step(3); bus1.cpu_req = 1'b0; bus1.cpu_we = 1'b0; bus1.cpu_wdata = '0; step(1);

    // owner changes fields and drops req after grant
    t = cyc;
    bus1.cpu_req = 1'b1; bus1.cpu_addr = 32'h40;
    mq1.push_back('{own: 1'b0, we: 1'b0, addr: 32'h40, wdata: 32'h0, cyc: t + 1});
    rq1.push_back('{port: 1'b0, rdata: mrd1(32'h40), cyc: t + 3});
    step(1);
    bus1.cpu_req = 1'b0; bus1.cpu_addr = 32'h44; bus1.cpu_we = 1'b1; bus1.cpu_wdata = 32'hFFFFFFFF;
    step(3);
    bus1.cpu_we = 1'b0; bus1.cpu_wdata = '0;

    // DMA read at MEM_LAT=3: capture only at t+4
    t = cyc;
    bus3.dma_req = 1'b1; bus3.dma_addr = 32'h100;
    mq3.push_back('{own: 1'b1, we: 1'b0, addr: 32'h100, wdata: 32'h0, cyc: t + 1});
    rq3.push_back('{port: 1'b1, rdata: {16'hC0DE, 16'(t + 4)}, cyc: t + 5});
    step(5); bus3.dma_req = 1'b0; step(1);

    t = cyc;
    bus3.cpu_req = 1'b1; bus3.cpu_addr = 32'h104;
    mq3.push_back('{own: 1'b0, we: 1'b0, addr: 32'h104, wdata: 32'h0, cyc: t + 1});
    rq3.push_back('{port: 1'b0, rdata: {16'hC0DE, 16'(t + 4)}, cyc: t + 5});
    step(5); bus3.cpu_req = 1'b0; step(1);

    // DMA read aborted by reset during WAIT
    t = cyc;
    bus3.dma_req = 1'b1; bus3.dma_addr = 32'h108;
    mq3.push_back('{own: 1'b1, we: 1'b0, addr: 32'h108, wdata: 32'h0, cyc: t + 1});
    step(3);
    check("gnt_wait3", 64'(bus3.gnt), 64'(2'b10));
    reset = 1'b0;
    #1;
    check("abort_gnt3", 64'(bus3.gnt), 64'(0));
    check("abort_mem_en3", 64'(bus3.mem_en), 64'(0));
    check("abort_ready3", 64'({bus3.cpu_ready, bus3.dma_ready}), 64'(0));
    check("abort_dma_rdata3", 64'(bus3.dma_rdata), 64'(0));
    check("abort_cpu_rdata1", 64'(bus1.cpu_rdata), 64'(0));
    bus1.cpu_req = 1'b1; bus1.cpu_addr = 32'h80; bus1.dma_req = 1'b1; bus1.dma_addr = 32'h90;
    bus3.cpu_req = 1'b1; bus3.cpu_addr = 32'h200; bus3.dma_addr = 32'h300;
    step(2);
    reset = 1'b1;

    // both held from release: CPU first, then alternate
    t = cyc;
    for (int i = 0; i < 4; i++) begin
      mq1.push_back('{own: i[0], we: 1'b0, addr: i[0] ? 32'h90 : 32'h80, wdata: 32'h0, cyc: t + 1 + 4 * i});
      rq1.push_back('{port: i[0], rdata: mrd1(i[0] ? 32'h90 : 32'h80), cyc: t + 3 + 4 * i});
    end
    for (int i = 0; i < 2; i++) begin
      mq3.push_back('{own: i[0], we: 1'b0, addr: i[0] ? 32'h300 : 32'h200, wdata: 32'h0, cyc: t + 1 + 6 * i});
      rq3.push_back('{port: i[0], rdata: {16'hC0DE, 16'(t + 4 + 6 * i)}, cyc: t + 5 + 6 * i});
    end
    step(5);  bus3.cpu_req = 1'b0;
    step(6);  bus1.cpu_req = 1'b0; bus3.dma_req = 1'b0;
    step(4);  bus1.dma_req = 1'b0;
    step(4);

    check("rq1_drained", 64'(rq1.size()), 64'(0));
    check("mq1_drained", 64'(mq1.size()), 64'(0));
    check("rq3_drained", 64'(rq3.size()), 64'(0));
    check("mq3_drained", 64'(mq3.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 32: address width.
REQ-002 Parameter DW, default 32: data width.
REQ-003 Parameter MEM_LAT, default 1, legal range 1..15: number of cycles from the mem_en cycle until mem_rdata is valid.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 cpu_req  input  1  CPU access request, held until cpu_ready.
REQ-007 cpu_we  input  1  CPU write (1) or read (0).
REQ-008 cpu_addr  input  AW  CPU byte address.
REQ-009 cpu_wdata  input  DW  CPU write data.
REQ-010 cpu_rdata  output  DW  CPU read data, registered.
REQ-011 cpu_ready  output  1  one-cycle completion pulse to CPU.
REQ-012 dma_req  input  1  DMA read request (display/audio fetch), held until dma_ready.
REQ-013 dma_addr  input  AW  DMA byte address.
REQ-014 dma_rdata  output  DW  DMA read data, registered.
REQ-015 dma_ready  output  1  one-cycle completion pulse to DMA.
REQ-016 mem_en  output  1  memory access strobe.
REQ-017 mem_we  output  1  memory write enable.
REQ-018 mem_addr  output  AW  memory address.
REQ-019 mem_wdata  output  DW  memory write data.
REQ-020 mem_rdata  input  DW  memory read data.
REQ-021 gnt  output  2  owner one-hot: bit0 = CPU, bit1 = DMA; 00 when idle.

Function
REQ-022 FSM states: IDLE, ISSUE, WAIT, DONE.
REQ-023 IDLE: if any req is high, select the owner, latch its addr, we and wdata, and go to ISSUE; otherwise stay.
REQ-024 Arbitration is round-robin via register last_owner: if both requests are high, grant the port that is not last_owner; if one is high, grant it.
REQ-025 DMA accesses are always reads: mem_we = 0 while DMA owns.
REQ-026 ISSUE: mem_en = 1 for exactly this cycle; mem_we, mem_addr and mem_wdata are driven from latched values; load wait counter with MEM_LAT; go to WAIT.
REQ-027 WAIT: decrement counter each cycle; on the cycle the counter reads 1, capture mem_rdata into the owner's rdata register (reads only) and go to DONE.
REQ-028 DONE: pulse the owner's ready for exactly one cycle; set last_owner to the owner; go to IDLE.
REQ-029 mem_en, mem_we, mem_addr and mem_wdata are 0 in every state except ISSUE.
REQ-030 gnt is the owner's one-hot value in ISSUE, WAIT and DONE, and 00 in IDLE.
REQ-031 Latency: with req high in IDLE cycle t, mem_en is high at t+1 and ready is high at t+2+MEM_LAT.
REQ-032 Writes complete with the same timing as reads; cpu_rdata is unchanged by a write.
REQ-033 rdata registers hold their value until that port's next read capture.
REQ-034 Address, data and we changes during an owned transaction are ignored, because latched values are used.
REQ-035 If the owner drops req mid-transaction, the transaction still completes and ready still pulses.
REQ-036 A request arriving outside IDLE waits; it is never lost while held.
REQ-037 The non-owner's ready is never asserted.
REQ-038 The arbiter never asserts both ready signals in the same cycle.

Reset
REQ-039 When reset is low, the following are cleared immediately (asynchronously): state = IDLE, counter = 0, last_owner = DMA (CPU wins first tie), cpu_rdata = 0, dma_rdata = 0, ready = 0, gnt = 00, and all mem_* outputs = 0.
REQ-040 Reset asserted mid-transaction aborts it without a ready pulse; after release, the arbiter samples requests fresh from IDLE.

Verification
REQ-041 MEM_LAT=1, CPU read addr 0x10 with memory returning 0xDEADBEEF -> mem_en at t+1 with mem_addr=0x10 and mem_we=0; cpu_ready at t+3; cpu_rdata=0xDEADBEEF.
REQ-042 CPU write addr 0x20, data 0x12345678 -> one mem_en cycle with mem_we=1 and mem_wdata=0x12345678; cpu_ready at t+3; cpu_rdata unchanged.
REQ-043 cpu_req and dma_req both held continuously from reset release -> grants alternate CPU, DMA, CPU, DMA; each ready pulses once per grant; never both ready in one cycle.
REQ-044 MEM_LAT=3, DMA read -> dma_ready at t+5; mem_rdata sampled at t+4 only.
REQ-045 Reset driven low during WAIT -> mem_en, gnt and ready go 0 immediately; no ready pulse; after release, the first tie goes to CPU.
REQ-046 cpu_addr changed and cpu_req dropped during WAIT -> the original address was used and cpu_ready still pulses once.
